// File: rtl/dbg_regfile_writer_if.sv
// rtl/dbg_regfile_writer_if.sv - debug read/write port between the debug writer and the register file
interface dbg_regfile_writer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RS_WIDTH   = 5
);
    logic                  dbg_we;
    logic [RS_WIDTH-1:0]   dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    modport master (
        output dbg_we,
        output dbg_addr,
        output dbg_wdata,
        input  dbg_rdata
    );

    modport slave (
        input  dbg_we,
        input  dbg_addr,
        input  dbg_wdata,
        output dbg_rdata
    );
endinterface

// File: rtl/dbg_regfile_writer.sv
// rtl/dbg_regfile_writer.sv - serial debug command port driving the register-file debug write/read port
module dbg_regfile_writer #(
    parameter int DATA_WIDTH  = 8,
    parameter int RS_WIDTH    = 5,
    parameter int FRAME_WIDTH = 2 + RS_WIDTH + DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 shift_en,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic                 capture,
    input  logic                 update,
    input  logic                 core_halted,
    output logic                 halt_req,
    output logic                 busy,
    dbg_regfile_writer_if.master dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_RDCAP = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_CTRL  = 2'b11;

    state_t                 state_q, state_d;
    logic [FRAME_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]             cmd_op_q, cmd_op_d;
    logic [RS_WIDTH-1:0]    cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0]  cmd_data_q, cmd_data_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   reject_q, reject_d;
    logic                   overrun_q, overrun_d;
    logic                   halt_q, halt_d;
    logic                   busy_q, busy_d;

    // State register and all datapath flops; reset aborts any in-flight command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cmd_op_q   <= OP_NOP;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            rdata_q    <= '0;
            reject_q   <= 1'b0;
            overrun_q  <= 1'b0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cmd_op_q   <= cmd_op_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            rdata_q    <= rdata_d;
            reject_q   <= reject_d;
            overrun_q  <= overrun_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
        end
    end

    // Shift/capture/update handling (capture > update > shift), then FSM; FSM flag sets come last so they win over a capture clear
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cmd_op_d   = cmd_op_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        rdata_d    = rdata_q;
        reject_d   = reject_q;
        overrun_d  = overrun_q;
        halt_d     = halt_q;

        if (capture) begin
            shift_d   = {overrun_q, reject_q, cmd_addr_q, rdata_q};
            reject_d  = 1'b0;
            overrun_d = 1'b0;
        end else if (update) begin
            if (state_q == S_IDLE) begin
                cmd_op_d   = shift_q[FRAME_WIDTH-1 -: 2];
                cmd_addr_d = shift_q[DATA_WIDTH +: RS_WIDTH];
                cmd_data_d = shift_q[DATA_WIDTH-1:0];
                state_d    = S_EXEC;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (shift_en) begin
            shift_d = {tdi, shift_q[FRAME_WIDTH-1:1]};
        end

        case (state_q)
            S_EXEC: begin
                state_d = S_IDLE;
                case (cmd_op_q)
                    OP_READ:  state_d = S_RDCAP;
                    OP_WRITE: begin
                        // x0 is hardwired: a write to it is a silent no-op
                        if (!core_halted && (cmd_addr_q != '0)) begin
                            reject_d = 1'b1;
                        end
                    end
                    OP_CTRL:  halt_d = cmd_data_q[0];
                    default:  ;
                endcase
            end
            S_RDCAP: begin
                rdata_d = dbg.dbg_rdata;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign tdo           = shift_q[0];
    assign halt_req      = halt_q;
    assign busy          = busy_q;
    assign dbg.dbg_addr  = cmd_addr_q;
    assign dbg.dbg_wdata = cmd_data_q;
    // Strobe decoded only from registered state/cmd plus the halt status, so it drops as soon as reset asserts
    assign dbg.dbg_we    = (state_q == S_EXEC) && (cmd_op_q == OP_WRITE)
                         && core_halted && (cmd_addr_q != '0);

endmodule

// File: tb/tb_dbg_regfile_writer.sv
// tb/tb_dbg_regfile_writer.sv - self-checking bench for dbg_regfile_writer
module tb_dbg_regfile_writer;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int FW = 2 + AW + DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic shift_en = 1'b0;
    logic tdi = 1'b0;
    logic capture = 1'b0;
    logic update = 1'b0;
    logic core_halted = 1'b0;
    logic tdo, halt_req, busy;

    dbg_regfile_writer_if #(.DATA_WIDTH(DW), .RS_WIDTH(AW)) dbg ();

    dbg_regfile_writer #(.DATA_WIDTH(DW), .RS_WIDTH(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .shift_en    (shift_en),
        .tdi         (tdi),
        .tdo         (tdo),
        .capture     (capture),
        .update      (update),
        .core_halted (core_halted),
        .halt_req    (halt_req),
        .busy        (busy),
        .dbg         (dbg)
    );

    always #5 clk = ~clk;

    // Register file environment: combinational read, write on strobe
    logic [DW-1:0] env_rf  [32];
    logic [DW-1:0] rf_seed [32];
    logic          rf_init = 1'b1;
    int            we_seen = 0;

    assign dbg.dbg_rdata = env_rf[dbg.dbg_addr];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) env_rf[i] <= rf_seed[i];
        end else if (dbg.dbg_we) begin
            env_rf[dbg.dbg_addr] <= dbg.dbg_wdata;
            we_seen <= we_seen + 1;
        end
    end

    // Reference model of architectural state
    logic [DW-1:0] m_regs [32];
    logic          m_halt = 1'b0;
    logic          m_rej = 1'b0;
    logic          m_ovr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_rdata = '0;
    int            m_we = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic h);
        m_addr = a;
        case (op)
            2'd1: m_rdata = m_regs[a];
            2'd2: if (a != 0) begin
                if (h) begin
                    m_regs[a] = d;
                    m_we++;
                end else begin
                    m_rej = 1'b1;
                end
            end
            2'd3: m_halt = d[0];
            default: ;
        endcase
    endtask

    task automatic shift_in(input logic [FW-1:0] f);
        for (int i = 0; i < FW; i++) begin
            shift_en = 1'b1;
            tdi = f[i];
            cyc();
        end
        shift_en = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic shift_out(output logic [FW-1:0] r);
        for (int i = 0; i < FW; i++) begin
            r[i] = tdo;
            shift_en = 1'b1;
            tdi = 1'b0;
            cyc();
        end
        shift_en = 1'b0;
    endtask

    task automatic capture_check(input string tag);
        logic [FW-1:0] exp, r;
        exp = {m_ovr, m_rej, m_addr, m_rdata};
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        m_rej = 1'b0;
        m_ovr = 1'b0;
        shift_out(r);
        chk(tag, r, exp);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic h);
        logic exp_we;
        core_halted = h;
        shift_in({op, a, d});
        update = 1'b1;
        cyc();
        update = 1'b0;
        exp_we = (op == 2'd2) && h && (a != 0);
        chk("busy_exec", busy, 1);
        chk("we_exec", dbg.dbg_we, exp_we);
        chk("addr_exec", dbg.dbg_addr, a);
        if (exp_we) chk("wdata_exec", dbg.dbg_wdata, d);
        model_cmd(op, a, d, h);
        cyc();
        chk("we_after", dbg.dbg_we, 0);
        chk("halt_req", halt_req, m_halt);
        cyc();
        cyc();
        chk("busy_idle", busy, 0);
        chk("we_count", we_seen, m_we);
    endtask

    initial begin
        logic [FW-1:0] r, exp;
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          h;

        for (int i = 0; i < 32; i++) begin
            rf_seed[i] = (i == 0) ? '0 : DW'($urandom);
            m_regs[i]  = rf_seed[i];
        end

        // Reset held with shift activity
        for (int i = 0; i < 6; i++) begin
            shift_en = 1'($urandom);
            tdi = 1'($urandom);
            cyc();
        end
        chk("rst_scalars", {tdo, busy, halt_req, dbg.dbg_we}, 0);
        chk("rst_addr", dbg.dbg_addr, 0);
        chk("rst_wdata", dbg.dbg_wdata, 0);
        shift_en = 1'b0;
        tdi = 1'b0;
        reset_n = 1'b1;
        rf_init = 1'b0;
        cyc();
        cyc();
        chk("post_rst_scalars", {tdo, busy, halt_req, dbg.dbg_we}, 0);
        capture_check("rst_resp");

        // Halt handshake and halted write
        run_cmd(2'd3, 5'd0, 8'h01, 1'b0);
        run_cmd(2'd2, 5'd3, 8'h5A, 1'b1);

        // Read back x3
        run_cmd(2'd1, 5'd3, 8'h00, 1'b1);
        capture_check("read_x3");

        // Rejected write while running
        run_cmd(2'd2, 5'd7, 8'hFF, 1'b0);
        capture_check("reject_set");
        capture_check("reject_clr");

        // Back-to-back update: second one dropped
        core_halted = 1'b1;
        shift_in({2'd2, 5'd4, 8'h33});
        update = 1'b1;
        cyc();
        model_cmd(2'd2, 5'd4, 8'h33, 1'b1);
        cyc();
        update = 1'b0;
        m_ovr = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("ovr_we_count", we_seen, m_we);
        capture_check("overrun");

        // Capture in the same cycle as a reject: the reject survives the clear
        core_halted = 1'b0;
        shift_in({2'd2, 5'd9, 8'h11});
        update = 1'b1;
        cyc();
        update = 1'b0;
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        m_addr = 5'd9;
        exp = {m_ovr, m_rej, m_addr, m_rdata};
        m_rej = 1'b0;
        m_ovr = 1'b0;
        model_cmd(2'd2, 5'd9, 8'h11, 1'b0);
        shift_out(r);
        chk("cap_during_exec", r, exp);
        capture_check("set_wins");

        // Write to x0 while halted
        run_cmd(2'd2, 5'd0, 8'hAA, 1'b1);
        capture_check("x0_write");

        // Reset during EXEC of a valid write
        core_halted = 1'b1;
        shift_in({2'd2, 5'd5, 8'h77});
        update = 1'b1;
        cyc();
        update = 1'b0;
        chk("we_before_rst", dbg.dbg_we, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("we_in_rst", dbg.dbg_we, 0);
        chk("busy_in_rst", busy, 0);
        cyc();
        reset_n = 1'b1;
        m_halt = 1'b0;
        m_rej = 1'b0;
        m_ovr = 1'b0;
        m_addr = '0;
        m_rdata = '0;
        cyc();
        chk("rst_abort_count", we_seen, m_we);
        capture_check("rst_abort_resp");

        // Randomized command stream
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = AW'($urandom);
            d  = DW'($urandom);
            h  = 1'($urandom);
            if (op == 2'd2 && a == 0) h = 1'b1;
            run_cmd(op, a, d, h);
            if ($urandom_range(0, 2) == 0) capture_check("rand_resp");
        end
        capture_check("final_resp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
